// File: rtl/seg7_scan_driver_if.sv
// Display bus between the digit source and the seven-segment scan driver.
// The driver takes the digit codes and decimal-point requests, and returns the enables and segments.
interface seg7_scan_driver_if;
  logic [31:0] number;
  logic [7:0]  dp_list;
  logic [7:0]  select;
  logic [6:0]  seg7;
  logic        dp;

  modport master (output number, output dp_list, input select, input seg7, input dp);
  modport slave  (input number, input dp_list, output select, output seg7, output dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment driver: registered one-cold digit ring advanced every CLK_DIV clks,
// combinational digit mux and hex decoder (zero latency from number/dp_list to seg7/dp); no backpressure.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam logic [15:0] DWELL_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  SEL_FIRST  = 8'b1111_1110;

  logic [15:0] dwell;
  logic [7:0]  sel_q;
  logic        sel_ok;
  logic [3:0]  code;
  logic        dp_mux;
  logic [6:0]  seg;

  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sel_q == ~(8'b1 << i)) sel_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_FIRST;
      dwell <= 16'd0;
    end else if (dwell >= DWELL_LAST) begin
      dwell <= 16'd0;
      // A corrupted ring is resynchronised to digit 0 rather than rotated.
      sel_q <= sel_ok ? {sel_q[6:0], sel_q[7]} : SEL_FIRST;
    end else begin
      dwell <= dwell + 16'd1;
    end
  end

  always_comb begin
    code   = 4'h0;
    dp_mux = 1'b0;
    case (sel_q)
      8'b1111_1110: begin code = bus.number[3:0];   dp_mux = bus.dp_list[0]; end
      8'b1111_1101: begin code = bus.number[7:4];   dp_mux = bus.dp_list[1]; end
      8'b1111_1011: begin code = bus.number[11:8];  dp_mux = bus.dp_list[2]; end
      8'b1111_0111: begin code = bus.number[15:12]; dp_mux = bus.dp_list[3]; end
      8'b1110_1111: begin code = bus.number[19:16]; dp_mux = bus.dp_list[4]; end
      8'b1101_1111: begin code = bus.number[23:20]; dp_mux = bus.dp_list[5]; end
      8'b1011_1111: begin code = bus.number[27:24]; dp_mux = bus.dp_list[6]; end
      8'b0111_1111: begin code = bus.number[31:28]; dp_mux = bus.dp_list[7]; end
      default:      begin code = 4'h0;              dp_mux = 1'b0;           end
    endcase
  end

  // Segment order is abcdefg, MSB first.
  always_comb begin
    seg = 7'b000_0000;
    case (code)
      4'h0: seg = 7'b111_1110;
      4'h1: seg = 7'b011_0000;
      4'h2: seg = 7'b110_1101;
      4'h3: seg = 7'b111_1001;
      4'h4: seg = 7'b011_0011;
      4'h5: seg = 7'b101_1011;
      4'h6: seg = 7'b101_1111;
      4'h7: seg = 7'b111_0000;
      4'h8: seg = 7'b111_1111;
      4'h9: seg = 7'b111_1011;
      4'hA: seg = 7'b111_0111;
      4'hB: seg = 7'b001_1111;
      4'hC: seg = 7'b100_1110;
      4'hD: seg = 7'b011_1101;
      4'hE: seg = 7'b100_1111;
      default: seg = 7'b000_0000;
    endcase
  end

  assign bus.select = sel_q;
  assign bus.seg7   = seg;
  assign bus.dp     = dp_mux;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance at CLK_DIV=1 and one at CLK_DIV=4 share a clock.
module tb_seg7_scan_driver;

  logic clk;
  logic rst1_n;
  logic rst4_n;
  int   vectors;
  int   miscompares;

  seg7_scan_driver_if bus1 ();
  seg7_scan_driver_if bus4 ();

  seg7_scan_driver #(.CLK_DIV(1)) u_div1 (.clk(clk), .rst_n(rst1_n), .bus(bus1.slave));
  seg7_scan_driver #(.CLK_DIV(4)) u_div4 (.clk(clk), .rst_n(rst4_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the CLK_DIV=1 instance just out of reset, at a falling edge, showing digit 0.
  task automatic reset1();
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_sel [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    bus1.number  = 32'h0000_0003;
    bus1.dp_list = 8'h01;
    @(posedge clk);
    #2;
    rst1_n = 1'b0;
    #1;
    vectors++;
    if (bus1.select !== 8'hFE) begin
      miscompares++;
      $display("FAIL reset_select got %h expected fe", bus1.select);
    end
    vectors++;
    if (bus1.seg7 !== 7'b111_1001 || bus1.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_digit0 got seg7=%b dp=%b expected 1111001 1", bus1.seg7, bus1.dp);
    end
    @(negedge clk);
    rst1_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus1.select !== exp_sel[i]) begin
        miscompares++;
        $display("FAIL reset_seq step %0d got %h expected %h", i, bus1.select, exp_sel[i]);
      end
    end
  endtask

  task automatic scan_frame(input string name, input logic [31:0] num, input logic [7:0] dps,
                            input logic [6:0] exp_seg [8]);
    bus1.number  = num;
    bus1.dp_list = dps;
    reset1();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus1.select !== ~(8'b1 << i) || bus1.seg7 !== exp_seg[i] || bus1.dp !== dps[i]) begin
        miscompares++;
        $display("FAIL %s digit %0d got sel=%h seg7=%b dp=%b expected sel=%h seg7=%b dp=%b",
                 name, i, bus1.select, bus1.seg7, bus1.dp, ~(8'b1 << i), exp_seg[i], dps[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_decimal();
    logic [6:0] e [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
    scan_frame("decimal", 32'h7654_3210, 8'h00, e);
  endtask

  task automatic test_blank();
    logic [6:0] e [8] = '{7'b1011011, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
    scan_frame("blank", 32'hFFFF_FFF5, 8'b0000_0100, e);
  endtask

  task automatic test_hex();
    logic [6:0] e [8] = '{7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                          7'b1001110, 7'b0111101, 7'b1001111, 7'b0000000};
    scan_frame("hex", 32'hFEDC_BA98, 8'hA5, e);
  endtask

  task automatic test_clk_div4();
    logic [7:0] exp;
    bus4.number  = 32'h0;
    bus4.dp_list = 8'h0;
    @(negedge clk);
    rst4_n = 1'b0;
    @(negedge clk);
    rst4_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      exp = ~(8'b1 << ((e / 4) % 8));
      vectors++;
      if (bus4.select !== exp) begin
        miscompares++;
        $display("FAIL div4 edge %0d got %h expected %h", e, bus4.select, exp);
      end
    end
  endtask

  task automatic test_live_update();
    bus1.number  = 32'h0000_0001;
    bus1.dp_list = 8'h00;
    reset1();
    vectors++;
    if (bus1.seg7 !== 7'b011_0000) begin
      miscompares++;
      $display("FAIL live_before got %b expected 0110000", bus1.seg7);
    end
    bus1.number = 32'h0000_0008;
    #1;
    vectors++;
    if (bus1.seg7 !== 7'b111_1111 || bus1.select !== 8'hFE) begin
      miscompares++;
      $display("FAIL live_after got seg7=%b sel=%h expected 1111111 fe", bus1.seg7, bus1.select);
    end
  endtask

  task automatic test_async_midframe();
    reset1();
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (bus1.select !== 8'hEF) begin
      miscompares++;
      $display("FAIL mid_pre got %h expected ef", bus1.select);
    end
    #1;
    rst1_n = 1'b0;
    #1;
    vectors++;
    if (bus1.select !== 8'hFE) begin
      miscompares++;
      $display("FAIL mid_reset got %h expected fe", bus1.select);
    end
    @(negedge clk);
    rst1_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus1.select !== 8'hFD) begin
      miscompares++;
      $display("FAIL mid_resume got %h expected fd", bus1.select);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst1_n       = 1'b1;
    rst4_n       = 1'b1;
    bus1.number  = 32'h0;
    bus1.dp_list = 8'h0;
    bus4.number  = 32'h0;
    bus4.dp_list = 8'h0;
    test_reset();
    test_decimal();
    test_blank();
    test_hex();
    test_clk_div4();
    test_live_update();
    test_async_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
